// File: rtl/shift_left_seq_pkg.sv
// Shared definitions for the sequential left shifter: default widths,
// FSM state encoding and a sizing helper for the stage counter.
package shift_left_seq_pkg;

  localparam int SLS_DATA_W  = 32;
  localparam int SLS_SHAMT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sls_state_e;

  // Stage counter only needs to count 0..shamt_w-1, but never narrower than 1 bit.
  function automatic int stage_cnt_w(input int shamt_w);
    return (shamt_w > 1) ? $clog2(shamt_w) : 1;
  endfunction

endpackage

// File: rtl/shift_left_seq_if.sv
// Request/result bundle of the sequential left shifter.
interface shift_left_seq_if
  import shift_left_seq_pkg::*;
#(
  parameter int DATA_W  = SLS_DATA_W,
  parameter int SHAMT_W = SLS_SHAMT_W
);

  logic               ctrl_start;
  logic [DATA_W-1:0]  data_operandA;
  logic [SHAMT_W-1:0] ctrl_shiftamt;
  logic [DATA_W-1:0]  data_result;
  logic               data_lost;
  logic               data_resultRDY;
  logic               busy;

  modport master (
    output ctrl_start, data_operandA, ctrl_shiftamt,
    input  data_result, data_lost, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_start, data_operandA, ctrl_shiftamt,
    output data_result, data_lost, data_resultRDY, busy
  );

endinterface

// File: rtl/shift_stage_left.sv
// One step of the log-shifter: shifts by 2**stage when shamt[stage] is set
// and reports the bits that fall off the top in that step.
module shift_stage_left
  import shift_left_seq_pkg::*;
#(
  parameter int DATA_W  = SLS_DATA_W,
  parameter int SHAMT_W = SLS_SHAMT_W,
  parameter int STAGE_W = stage_cnt_w(SHAMT_W)
) (
  input  logic [DATA_W-1:0]  data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [STAGE_W-1:0] stage,
  output logic [DATA_W-1:0]  data_out,
  output logic [DATA_W-1:0]  lost_mask
);

  logic [DATA_W-1:0] shifted [SHAMT_W];
  logic [DATA_W-1:0] dropped [SHAMT_W];

  // Every fixed-distance candidate is built in parallel; the stage index picks one.
  generate
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      localparam int                SH   = 1 << gi;
      localparam logic [DATA_W-1:0] KEEP = {DATA_W{1'b1}} >> SH;
      assign shifted[gi] = data_in << SH;
      assign dropped[gi] = data_in & ~KEEP;
    end
  endgenerate

  always_comb begin
    data_out  = data_in;
    lost_mask = '0;
    for (int k = 0; k < SHAMT_W; k++) begin
      if ((stage == STAGE_W'(k)) && shamt[k]) begin
        data_out  = shifted[k];
        lost_mask = dropped[k];
      end
    end
  end

endmodule

// File: rtl/shift_left_seq.sv
// Sequential logical left shifter: one shift-amount bit per cycle, LSB first,
// fixed latency regardless of the amount, with a sticky lost-bit flag.
module shift_left_seq
  import shift_left_seq_pkg::*;
#(
  parameter int DATA_W  = SLS_DATA_W,
  parameter int SHAMT_W = SLS_SHAMT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  shift_left_seq_if.slave  bus
);

  localparam int                 STAGE_W    = stage_cnt_w(SHAMT_W);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(SHAMT_W - 1);

  generate
    if (DATA_W != (1 << SHAMT_W)) begin : g_cfg_check
      $error("shift_left_seq: DATA_W must equal 2**SHAMT_W");
    end
  endgenerate

  sls_state_e         state_q,  state_d;
  logic [STAGE_W-1:0] stage_q,  stage_d;
  logic [SHAMT_W-1:0] shamt_q,  shamt_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               lost_q,   lost_d;

  logic [DATA_W-1:0]  stage_out;
  logic [DATA_W-1:0]  stage_lost;

  shift_stage_left #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W),
    .STAGE_W (STAGE_W)
  ) u_stage (
    .data_in   (result_q),
    .shamt     (shamt_q),
    .stage     (stage_q),
    .data_out  (stage_out),
    .lost_mask (stage_lost)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      stage_q  <= '0;
      shamt_q  <= '0;
      result_q <= '0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      shamt_q  <= shamt_d;
      result_q <= result_d;
      lost_q   <= lost_d;
    end
  end

  // The result register doubles as the working register, so it holds the
  // last answer in IDLE and is only overwritten when a new start is taken.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    shamt_d  = shamt_q;
    result_d = result_q;
    lost_d   = lost_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.ctrl_start) begin
          result_d = bus.data_operandA;
          shamt_d  = bus.ctrl_shiftamt;
          lost_d   = 1'b0;
          stage_d  = '0;
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        result_d = stage_out;
        lost_d   = lost_q | (|stage_lost);
        if (stage_q == LAST_STAGE) begin
          state_d = ST_DONE;
        end else begin
          stage_d = stage_q + STAGE_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        // A start here chains straight into the next operation.
        if (bus.ctrl_start) begin
          result_d = bus.data_operandA;
          shamt_d  = bus.ctrl_shiftamt;
          lost_d   = 1'b0;
          stage_d  = '0;
          state_d  = ST_SHIFT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.data_result    = result_q;
  assign bus.data_lost      = lost_q;
  assign bus.data_resultRDY = (state_q == ST_DONE);
  assign bus.busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_left_seq.sv
// Directed and randomized checks of shift_left_seq: latency, lost flag,
// back-to-back starts and asynchronous reset abort.
module tb_shift_left_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  shift_left_seq_if #(.DATA_W(32), .SHAMT_W(5)) bus ();

  shift_left_seq #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [4:0] amt);
    return a << amt;
  endfunction

  function automatic logic ref_lost(input logic [31:0] a, input logic [4:0] amt);
    logic [31:0] hi;
    if (amt == 5'd0) return 1'b0;
    hi = a >> (6'd32 - {1'b0, amt});
    return |hi;
  endfunction

  // Starts one operation, scrambles the inputs after acceptance and waits
  // (bounded) for the ready pulse; cyc counts the acceptance edge as 1.
  task automatic run_op(input logic [31:0] a, input logic [4:0] amt,
                        output logic [31:0] res, output logic lost, output int cyc);
    @(negedge clk);
    bus.ctrl_start    = 1'b1;
    bus.data_operandA = a;
    bus.ctrl_shiftamt = amt;
    @(negedge clk);
    bus.ctrl_start    = 1'b0;
    bus.data_operandA = $urandom;
    bus.ctrl_shiftamt = 5'($urandom_range(0, 31));
    cyc  = 1;
    res  = 32'h0;
    lost = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.data_resultRDY) begin
        res  = bus.data_result;
        lost = bus.data_lost;
        break;
      end
    end
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [4:0] amt,
                          input logic [31:0] exp_res, input logic exp_lost);
    logic [31:0] res;
    logic        lost;
    int          cyc;
    run_op(a, amt, res, lost, cyc);
    check({tag, "_result"}, res, exp_res);
    check({tag, "_lost"}, {31'b0, lost}, {31'b0, exp_lost});
    check({tag, "_latency"}, cyc, 6);
    @(posedge clk);
    #1;
    check({tag, "_rdy_pulse_end"}, {31'b0, bus.data_resultRDY}, 32'd0);
    check({tag, "_idle_busy"}, {31'b0, bus.busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold"}, bus.data_result, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] res;
    logic        lost;
    int          cyc;
    int          pulses;
    logic [31:0] a;
    logic [4:0]  amt;

    bus.ctrl_start    = 1'b0;
    bus.data_operandA = 32'h0;
    bus.ctrl_shiftamt = 5'd0;

    #12;
    check("reset_result", bus.data_result, 32'h0);
    check("reset_lost", {31'b0, bus.data_lost}, 32'd0);
    check("reset_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    directed("amt31", 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
    directed("amt4_lost", 32'hF000_0001, 5'd4, 32'h0000_0010, 1'b1);
    directed("amt0", 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0);

    // Start held high with operands changing every cycle.
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      bus.ctrl_start    = (n < 12);
      bus.data_operandA = 32'h0101_0101 * (n + 1);
      bus.ctrl_shiftamt = 5'(n + 1);
      @(posedge clk);
      #1;
      if (bus.data_resultRDY) begin
        pulses++;
        if (pulses == 1) begin
          check("b2b_first_at", n, 5);
          check("b2b_first_result", bus.data_result, 32'h0202_0202);
          check("b2b_first_lost", {31'b0, bus.data_lost}, 32'd0);
        end else if (pulses == 2) begin
          check("b2b_second_at", n, 11);
          check("b2b_second_result", bus.data_result, 32'h8383_8380);
          check("b2b_second_lost", {31'b0, bus.data_lost}, 32'd1);
        end
      end
    end
    check("b2b_pulse_count", pulses, 2);

    // Asynchronous reset while stage 2 is in progress.
    @(negedge clk);
    bus.ctrl_start    = 1'b1;
    bus.data_operandA = 32'hFFFF_FFFF;
    bus.ctrl_shiftamt = 5'd31;
    @(negedge clk);
    bus.ctrl_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    check("abort_busy_before", {31'b0, bus.busy}, 32'd1);
    check("abort_result_before", bus.data_result, 32'hFFFF_FFF8);
    rst_n = 1'b0;
    #1;
    check("abort_result", bus.data_result, 32'h0);
    check("abort_lost", {31'b0, bus.data_lost}, 32'd0);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (bus.data_resultRDY) pulses++;
    end
    check("abort_no_rdy", pulses, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    directed("after_abort", 32'h0000_00FF, 5'd8, 32'h0000_FF00, 1'b0);

    for (int r = 0; r < 1000; r++) begin
      a   = $urandom;
      amt = 5'($urandom_range(0, 31));
      run_op(a, amt, res, lost, cyc);
      check("rand_result", res, ref_res(a, amt));
      check("rand_lost", {31'b0, lost}, {31'b0, ref_lost(a, amt)});
      check("rand_latency", cyc, 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
